date_engine: RTL and testbench

DATE_ENGINE -- requirements
Module: date_engine

---
 rtl/date_engine.sv | 171 +++++++++++++++++
 tb/tb_date_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/date_engine.sv
// Calendar date/day-of-week register with end-of-day advance, manual adjust and checked load.
// All outputs come straight from flops; at most one action is applied per clock.
module date_engine #(
  parameter int YEAR_MIN      = 2000,
  parameter int YEAR_MAX      = 2099,
  parameter int DEFAULT_DAY   = 1,
  parameter int DEFAULT_MONTH = 9,
  parameter int DEFAULT_YEAR  = 2001,
  parameter int DEFAULT_DOW   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        end_of_day,
  input  logic        adj_day,
  input  logic        adj_month,
  input  logic        adj_year,
  input  logic        adj_down,
  input  logic        load,
  input  logic [4:0]  ld_day,
  input  logic [3:0]  ld_month,
  input  logic [11:0] ld_year,
  input  logic [2:0]  ld_dow,
  output logic [4:0]  day,
  output logic [3:0]  month,
  output logic [11:0] year,
  output logic [2:0]  dow,
  output logic        month_wrap,
  output logic        year_wrap,
  output logic        load_err
);

  localparam logic [11:0] YMIN      = 12'(YEAR_MIN);
  localparam logic [11:0] YMAX      = 12'(YEAR_MAX);
  localparam logic [4:0]  DEF_DAY   = 5'(DEFAULT_DAY);
  localparam logic [3:0]  DEF_MONTH = 4'(DEFAULT_MONTH);
  localparam logic [11:0] DEF_YEAR  = 12'(DEFAULT_YEAR);
  localparam logic [2:0]  DEF_DOW   = 3'(DEFAULT_DOW);

  function automatic logic is_leap(input logic [11:0] y);
    return (y[1:0] == 2'b00) && (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [11:0] y);
    case (m)
      4'd2:                     return is_leap(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
      default:                  return 5'd31;
    endcase
  endfunction

  function automatic logic date_ok(input logic [4:0] d, input logic [3:0] m,
                                   input logic [11:0] y, input logic [2:0] w);
    return (m >= 4'd1) && (m <= 4'd12) && (d >= 5'd1) && (d <= month_len(m, y)) &&
           (y >= YMIN) && (y <= YMAX) && (w <= 3'd6);
  endfunction

  function automatic logic [11:0] year_step(input logic [11:0] y, input logic down);
    if (down) return (y == YMIN) ? YMAX : y - 12'd1;
    else      return (y == YMAX) ? YMIN : y + 12'd1;
  endfunction

  function automatic logic [2:0] dow_step(input logic [2:0] w, input logic down);
    if (down) return (w == 3'd0) ? 3'd6 : w - 3'd1;
    else      return (w == 3'd6) ? 3'd0 : w + 3'd1;
  endfunction

  logic [4:0]  day_q,   day_d;
  logic [3:0]  month_q, month_d;
  logic [11:0] year_q,  year_d;
  logic [2:0]  dow_q,   dow_d;
  logic        month_wrap_q, month_wrap_d;
  logic        year_wrap_q,  year_wrap_d;
  logic        load_err_q,   load_err_d;

  logic [4:0]  cur_len;
  logic [3:0]  adj_m;
  logic [11:0] adj_y;
  logic [4:0]  adj_len;

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    day_d        = day_q;
    month_d      = month_q;
    year_d       = year_q;
    dow_d        = dow_q;
    month_wrap_d = 1'b0;
    year_wrap_d  = 1'b0;
    load_err_d   = 1'b0;
    cur_len      = month_len(month_q, year_q);
    adj_m        = month_q;
    adj_y        = year_q;

    if (adj_year) begin
      adj_y = year_step(year_q, adj_down);
    end else if (adj_month) begin
      if (adj_down) adj_m = (month_q == 4'd1)  ? 4'd12 : month_q - 4'd1;
      else          adj_m = (month_q == 4'd12) ? 4'd1  : month_q + 4'd1;
    end
    adj_len = month_len(adj_m, adj_y);

    if (!date_ok(day_q, month_q, year_q, dow_q)) begin
      // Corrupted state recovers to the reset date rather than propagating garbage.
      day_d   = DEF_DAY;
      month_d = DEF_MONTH;
      year_d  = DEF_YEAR;
      dow_d   = DEF_DOW;
    end else if (load) begin
      if (date_ok(ld_day, ld_month, ld_year, ld_dow)) begin
        day_d   = ld_day;
        month_d = ld_month;
        year_d  = ld_year;
        dow_d   = ld_dow;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (adj_year || adj_month) begin
      month_d = adj_m;
      year_d  = adj_y;
      day_d   = (day_q > adj_len) ? adj_len : day_q;
    end else if (adj_day) begin
      if (adj_down) day_d = (day_q == 5'd1) ? cur_len : day_q - 5'd1;
      else          day_d = (day_q == cur_len) ? 5'd1 : day_q + 5'd1;
      dow_d = dow_step(dow_q, adj_down);
    end else if (end_of_day) begin
      dow_d = dow_step(dow_q, 1'b0);
      if (day_q == cur_len) begin
        day_d        = 5'd1;
        month_wrap_d = 1'b1;
        if (month_q == 4'd12) begin
          month_d     = 4'd1;
          year_d      = year_step(year_q, 1'b0);
          year_wrap_d = 1'b1;
        end else begin
          month_d = month_q + 4'd1;
        end
      end else begin
        day_d = day_q + 5'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      day_q        <= DEF_DAY;
      month_q      <= DEF_MONTH;
      year_q       <= DEF_YEAR;
      dow_q        <= DEF_DOW;
      month_wrap_q <= 1'b0;
      year_wrap_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      dow_q        <= dow_d;
      month_wrap_q <= month_wrap_d;
      year_wrap_q  <= year_wrap_d;
      load_err_q   <= load_err_d;
    end
  end

  assign day        = day_q;
  assign month      = month_q;
  assign year       = year_q;
  assign dow        = dow_q;
  assign month_wrap = month_wrap_q;
  assign year_wrap  = year_wrap_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_date_engine.sv
// Directed bench for date_engine: a default-range instance plus one whose range reaches 2100.
// Inputs are driven on the falling edge and outputs checked on the next falling edge.
module tb_date_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        end_of_day, adj_day, adj_month, adj_year, adj_down, load;
  logic [4:0]  ld_day;
  logic [3:0]  ld_month;
  logic [11:0] ld_year;
  logic [2:0]  ld_dow;

  logic [4:0]  day,  day2;
  logic [3:0]  month, month2;
  logic [11:0] year, year2;
  logic [2:0]  dow,  dow2;
  logic        month_wrap, year_wrap, load_err;
  logic        month_wrap2, year_wrap2, load_err2;

  int checks = 0;
  int errors = 0;
  int wraps;

  always #5 clk = ~clk;

  date_engine dut (
    .clk(clk), .reset(reset), .end_of_day(end_of_day), .adj_day(adj_day),
    .adj_month(adj_month), .adj_year(adj_year), .adj_down(adj_down), .load(load),
    .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year), .ld_dow(ld_dow),
    .day(day), .month(month), .year(year), .dow(dow),
    .month_wrap(month_wrap), .year_wrap(year_wrap), .load_err(load_err)
  );

  date_engine #(.YEAR_MAX(2100)) dut2 (
    .clk(clk), .reset(reset), .end_of_day(end_of_day), .adj_day(adj_day),
    .adj_month(adj_month), .adj_year(adj_year), .adj_down(adj_down), .load(load),
    .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year), .ld_dow(ld_dow),
    .day(day2), .month(month2), .year(year2), .dow(dow2),
    .month_wrap(month_wrap2), .year_wrap(year_wrap2), .load_err(load_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_date(input string tag, input int d, input int m, input int y, input int w);
    check({tag, ".day"},   32'(day),   32'(d));
    check({tag, ".month"}, 32'(month), 32'(m));
    check({tag, ".year"},  32'(year),  32'(y));
    check({tag, ".dow"},   32'(dow),   32'(w));
  endtask

  task automatic check_pulses(input string tag, input logic mw, input logic yw, input logic le);
    check({tag, ".month_wrap"}, 32'(month_wrap), 32'(mw));
    check({tag, ".year_wrap"},  32'(year_wrap),  32'(yw));
    check({tag, ".load_err"},   32'(load_err),   32'(le));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    end_of_day = 1'b0; adj_day = 1'b0; adj_month = 1'b0;
    adj_year = 1'b0; adj_down = 1'b0; load = 1'b0;
  endtask

  task automatic do_load(input int d, input int m, input int y, input int w);
    ld_day = 5'(d); ld_month = 4'(m); ld_year = 12'(y); ld_dow = 3'(w);
    load = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    end_of_day = 1'b0; adj_day = 1'b0; adj_month = 1'b0;
    adj_year = 1'b0; adj_down = 1'b0; load = 1'b0;
    ld_day = '0; ld_month = '0; ld_year = '0; ld_dow = '0;
    #1;
    check_date("reset", 1, 9, 2001, 6);
    check_pulses("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_date("idle", 1, 9, 2001, 6);

    // 01/09/2001 + 121 days = 31/12/2001 (Monday), crossing three month ends.
    wraps = 0;
    for (int i = 1; i <= 121; i++) begin
      end_of_day = 1'b1;
      tick();
      if (month_wrap) wraps++;
      if (i == 29) check_date("sep30", 30, 9, 2001, 0);
    end
    check_date("dec31", 31, 12, 2001, 1);
    check("wrap_count", 32'(wraps), 32'd3);
    end_of_day = 1'b1;
    tick();
    check_date("jan1_2002", 1, 1, 2002, 2);
    check_pulses("jan1_2002", 1'b1, 1'b1, 1'b0);
    tick();
    check_pulses("no_action", 1'b0, 1'b0, 1'b0);

    // Year wrap at the top of the range.
    do_load(31, 12, 2099, 4);
    check_date("ld_2099", 31, 12, 2099, 4);
    check_pulses("ld_2099", 1'b0, 1'b0, 1'b0);
    end_of_day = 1'b1;
    tick();
    check_date("wrap_2000", 1, 1, 2000, 5);
    check_pulses("wrap_2000", 1'b1, 1'b1, 1'b0);
    check("dut2.year_2100", 32'(year2), 32'd2100);

    // 2100 is not leap: only the wide-range instance accepts it.
    do_load(28, 2, 2100, 0);
    check("ld_2100.err", 32'(load_err), 32'd1);
    check_date("ld_2100.kept", 1, 1, 2000, 5);
    check("dut2.ld_err", 32'(load_err2), 32'd0);
    end_of_day = 1'b1;
    tick();
    check("dut2.mar1.day", 32'(day2), 32'd1);
    check("dut2.mar1.month", 32'(month2), 32'd3);
    check("dut2.mar1.year", 32'(year2), 32'd2100);
    check("dut2.mar1.mwrap", 32'(month_wrap2), 32'd1);

    do_load(28, 2, 2000, 1);
    end_of_day = 1'b1;
    tick();
    check_date("feb29_2000", 29, 2, 2000, 2);
    check_pulses("feb29_2000", 1'b0, 1'b0, 1'b0);
    end_of_day = 1'b1;
    tick();
    check_date("mar1_2000", 1, 3, 2000, 3);
    check_pulses("mar1_2000", 1'b1, 1'b0, 1'b0);

    // Adjust with day clamping and in-month wrap.
    do_load(31, 1, 2023, 2);
    adj_month = 1'b1;
    tick();
    check_date("clamp_feb", 28, 2, 2023, 2);
    check_pulses("clamp_feb", 1'b0, 1'b0, 1'b0);
    do_load(1, 2, 2023, 3);
    adj_day = 1'b1; adj_down = 1'b1;
    tick();
    check_date("day_down", 28, 2, 2023, 2);
    check_pulses("day_down", 1'b0, 1'b0, 1'b0);
    adj_day = 1'b1;
    tick();
    check_date("day_up", 1, 2, 2023, 3);

    // Invalid loads leave state alone and pulse load_err once.
    do_load(30, 2, 2024, 4);
    check("bad_feb30.err", 32'(load_err), 32'd1);
    check_date("bad_feb30", 1, 2, 2023, 3);
    tick();
    check("err_clears", 32'(load_err), 32'd0);
    do_load(10, 5, 2024, 7);
    check("bad_dow.err", 32'(load_err), 32'd1);
    do_load(10, 5, 1999, 1);
    check("bad_year.err", 32'(load_err), 32'd1);
    do_load(10, 13, 2024, 1);
    check("bad_month.err", 32'(load_err), 32'd1);
    check_date("bad_kept", 1, 2, 2023, 3);

    // Load wins over end_of_day in the same cycle.
    end_of_day = 1'b1;
    do_load(29, 2, 2024, 4);
    check_date("load_prio", 29, 2, 2024, 4);
    check_pulses("load_prio", 1'b0, 1'b0, 1'b0);
    adj_year = 1'b1;
    tick();
    check_date("yr_clamp", 28, 2, 2025, 4);
    adj_year = 1'b1; adj_month = 1'b1; adj_day = 1'b1;
    tick();
    check_date("yr_prio", 28, 2, 2026, 4);

    // Year wrap in both directions, month wrap downward.
    do_load(29, 2, 2000, 2);
    adj_year = 1'b1; adj_down = 1'b1;
    tick();
    check_date("yr_down_wrap", 28, 2, 2099, 2);
    check_pulses("yr_down_wrap", 1'b0, 1'b0, 1'b0);
    adj_year = 1'b1;
    tick();
    check_date("yr_up_wrap", 28, 2, 2000, 2);
    do_load(15, 1, 2050, 6);
    adj_month = 1'b1; adj_down = 1'b1;
    tick();
    check_date("mon_down_wrap", 15, 12, 2050, 6);

    // Reset in the middle of a pulse discards it and takes effect at once.
    end_of_day = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_date("mid_reset", 1, 9, 2001, 6);
    @(posedge clk);
    @(negedge clk);
    check_date("reset_held", 1, 9, 2001, 6);
    check_pulses("reset_held", 1'b0, 1'b0, 1'b0);
    end_of_day = 1'b0;
    reset = 1'b0;
    end_of_day = 1'b1;
    tick();
    check_date("first_after_rst", 2, 9, 2001, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
